// File: rtl/panda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : panda_pkg
// Description : Shared types for the Panda pipeline EX stage and the
//               iterative RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package panda_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    // Encoding follows the RV32M funct3 field.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_MUL  = 2'd1,
        MDS_DIV  = 2'd2,
        MDS_DONE = 2'd3
    } md_state_e;

    typedef enum logic [1:0] {
        RD_DATA_ALU = 2'd0,
        RD_DATA_MEM = 2'd1,
        RD_DATA_PC  = 2'd2
    } rd_data_sel_e;

    typedef struct packed {
        logic         valid;
        logic [31:0]  pc_inc;
        logic [4:0]   rs1_addr;
        logic [31:0]  rs1_data;
        logic [4:0]   rs2_addr;
        logic [31:0]  rs2_data;
        logic [31:0]  imm;
        alu_op_e      alu_op;
        logic         alu_src_imm;
        logic         md_en;
        md_op_e       md_op;
        logic         lsu_load;
        logic         lsu_store;
        logic [1:0]   lsu_width;
        logic         lsu_unsigned;
        logic [4:0]   rd_addr;
        logic         rd_we;
        rd_data_sel_e rd_data_sel;
    } id_ex_t;

    typedef struct packed {
        logic [31:0]  alu_result;
        logic [31:0]  rs2_data;
        logic [4:0]   rs2_addr;
        logic [31:0]  imm;
        logic [31:0]  pc_inc;
        logic         lsu_load;
        logic         lsu_store;
        logic [1:0]   lsu_width;
        logic         lsu_unsigned;
        logic [4:0]   rd_addr;
        logic         rd_we;
        rd_data_sel_e rd_data_sel;
    } ex_mem_t;

    function automatic logic [31:0] alu_compute(input alu_op_e op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] res;
        case (op)
            ALU_ADD:    res = a + b;
            ALU_SUB:    res = a - b;
            ALU_SLL:    res = a << b[4:0];
            ALU_SLT:    res = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:   res = {31'b0, a < b};
            ALU_XOR:    res = a ^ b;
            ALU_SRL:    res = a >> b[4:0];
            ALU_SRA:    res = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:     res = a | b;
            ALU_AND:    res = a & b;
            ALU_PASS_B: res = b;
            default:    res = a + b;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/panda_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : panda_muldiv
// Description : Iterative RV32M unit: 1-bit/cycle shift-add multiply and
//               restoring divide on magnitudes, sign-corrected in DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module panda_muldiv
    import panda_pkg::*;
#(
    parameter bit MD_FAST_SPECIAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  md_op_e      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    md_state_e   r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    md_op_e      r_op;
    logic        r_neg_res;
    logic        r_neg_rem;

    logic        w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
    logic [31:0] w_a_mag, w_b_mag;
    logic        w_div_zero, w_div_ovf, w_special;
    logic [32:0] w_mul_sum;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_prod;
    logic [31:0] w_quo, w_rem;

    assign w_is_div   = i_op[2];
    assign w_a_signed = (i_op == MD_MULH) || (i_op == MD_MULHSU) ||
                        (i_op == MD_DIV)  || (i_op == MD_REM);
    assign w_b_signed = (i_op == MD_MULH) || (i_op == MD_DIV) || (i_op == MD_REM);
    assign w_sa       = w_a_signed & i_a[31];
    assign w_sb       = w_b_signed & i_b[31];
    assign w_a_mag    = w_sa ? -i_a : i_a;
    assign w_b_mag    = w_sb ? -i_b : i_b;
    assign w_div_zero = w_is_div && (i_b == 32'h0);
    assign w_div_ovf  = ((i_op == MD_DIV) || (i_op == MD_REM)) &&
                        (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    generate
        if (MD_FAST_SPECIAL) begin : g_fast_special
            assign w_special = w_div_zero | w_div_ovf;
        end else begin : g_no_fast_special
            assign w_special = 1'b0;
        end
    endgenerate

    // Multiply: multiplier sits in the low half and shifts out LSB first.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    // Divide: partial remainder is the upper half shifted left by one.
    assign w_div_ge   = (r_acc[63:31] >= {1'b0, r_opnd});
    assign w_div_diff = r_acc[62:31] - r_opnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MDS_IDLE;
            r_cnt     <= 5'd0;
            r_acc     <= 64'd0;
            r_opnd    <= 32'd0;
            r_op      <= MD_MUL;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (i_flush) begin
            r_state <= MDS_IDLE;
        end else begin
            case (r_state)
                MDS_IDLE: begin
                    if (i_start) begin
                        r_op      <= i_op;
                        r_cnt     <= 5'd31;
                        r_neg_res <= (w_sa ^ w_sb) & ~w_div_zero;
                        r_neg_rem <= w_sa;
                        if (w_special) begin
                            r_acc     <= w_div_zero ? {i_a, 32'hFFFF_FFFF}
                                                    : {32'h0, 32'h8000_0000};
                            r_neg_res <= 1'b0;
                            r_neg_rem <= 1'b0;
                            r_state   <= MDS_DONE;
                        end else if (w_is_div) begin
                            r_acc   <= {32'h0, w_a_mag};
                            r_opnd  <= w_b_mag;
                            r_state <= MDS_DIV;
                        end else begin
                            r_acc   <= {32'h0, w_b_mag};
                            r_opnd  <= w_a_mag;
                            r_state <= MDS_MUL;
                        end
                    end
                end
                MDS_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[31:1]};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) r_state <= MDS_DONE;
                end
                MDS_DIV: begin
                    r_acc <= w_div_ge ? {w_div_diff, r_acc[30:0], 1'b1}
                                      : {r_acc[62:0], 1'b0};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) r_state <= MDS_DONE;
                end
                default: r_state <= MDS_IDLE;
            endcase
        end
    end

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[31:0] : r_acc[31:0];
    assign w_rem  = r_neg_rem ? -r_acc[63:32] : r_acc[63:32];

    always_comb begin
        o_result = w_rem;
        case (r_op)
            MD_MUL:                        o_result = w_prod[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  o_result = w_prod[63:32];
            MD_DIV, MD_DIVU:               o_result = w_quo;
            default:                       o_result = w_rem;
        endcase
    end

    assign o_busy = (r_state == MDS_MUL) || (r_state == MDS_DIV);
    assign o_done = (r_state == MDS_DONE);

endmodule
`default_nettype wire

// File: rtl/panda_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : panda_ex_stage
// Description : Panda execute stage: operand forwarding, single-cycle ALU,
//               iterative multiply/divide and the EX/MEM register.
// Revision    : 1.0 - initial release
// ============================================================================
module panda_ex_stage
    import panda_pkg::*;
#(
    parameter bit MD_FAST_SPECIAL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  id_ex_t      id_ex_i,
    input  logic [31:0] wb_rd_data_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic        wb_rd_we_i,
    input  logic        flush_i,
    output logic        stall_o,
    output ex_mem_t     ex_mem_o
);

    logic [31:0] w_rs1, w_rs2, w_op_b, w_alu_result, w_md_result;
    logic        w_md_start, w_md_busy, w_md_done;
    ex_mem_t     w_ex_next;

    // Loads in EX/MEM are never forwarded; ID stalls on load-use.
    function automatic logic [31:0] f_forward(input logic [4:0]  addr,
                                              input logic [31:0] id_data,
                                              input ex_mem_t     em,
                                              input logic        wb_we,
                                              input logic [4:0]  wb_addr,
                                              input logic [31:0] wb_data);
        logic [31:0] val;
        val = id_data;
        if (addr != 5'd0) begin
            if (em.rd_we && (em.rd_addr == addr) && (em.rd_data_sel == RD_DATA_ALU))
                val = em.alu_result;
            else if (wb_we && (wb_addr == addr))
                val = wb_data;
        end
        return val;
    endfunction

    assign w_rs1 = f_forward(id_ex_i.rs1_addr, id_ex_i.rs1_data, ex_mem_o,
                             wb_rd_we_i, wb_rd_addr_i, wb_rd_data_i);
    assign w_rs2 = f_forward(id_ex_i.rs2_addr, id_ex_i.rs2_data, ex_mem_o,
                             wb_rd_we_i, wb_rd_addr_i, wb_rd_data_i);

    assign w_op_b       = id_ex_i.alu_src_imm ? id_ex_i.imm : w_rs2;
    assign w_alu_result = alu_compute(id_ex_i.alu_op, w_rs1, w_op_b);

    assign w_md_start = id_ex_i.valid & id_ex_i.md_en & ~flush_i;
    assign stall_o    = w_md_busy | (w_md_start & ~w_md_busy & ~w_md_done);

    panda_muldiv #(
        .MD_FAST_SPECIAL (MD_FAST_SPECIAL)
    ) u_muldiv (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_start  (w_md_start),
        .i_op     (id_ex_i.md_op),
        .i_a      (w_rs1),
        .i_b      (w_rs2),
        .i_flush  (flush_i),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    always_comb begin
        w_ex_next              = '0;
        w_ex_next.alu_result   = w_md_done ? w_md_result : w_alu_result;
        w_ex_next.rs2_data     = w_rs2;
        w_ex_next.rs2_addr     = id_ex_i.rs2_addr;
        w_ex_next.imm          = id_ex_i.imm;
        w_ex_next.pc_inc       = id_ex_i.pc_inc;
        w_ex_next.lsu_load     = id_ex_i.lsu_load;
        w_ex_next.lsu_store    = id_ex_i.lsu_store;
        w_ex_next.lsu_width    = id_ex_i.lsu_width;
        w_ex_next.lsu_unsigned = id_ex_i.lsu_unsigned;
        w_ex_next.rd_addr      = id_ex_i.rd_addr;
        w_ex_next.rd_we        = id_ex_i.rd_we;
        w_ex_next.rd_data_sel  = id_ex_i.rd_data_sel;
    end

    // A held multi-cycle instruction is emitted only once, on its DONE edge.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            ex_mem_o <= '0;
        else if (flush_i || stall_o || !(id_ex_i.valid || w_md_done))
            ex_mem_o <= '0;
        else
            ex_mem_o <= w_ex_next;
    end

endmodule
`default_nettype wire

// File: tb/tb_panda_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_panda_ex_stage
// Description : Self-checking bench for panda_ex_stage against a behavioural
//               reference model with directed and random instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_panda_ex_stage;
    import panda_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    id_ex_t      r_id_ex;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_addr;
    logic        r_wb_we;
    logic        r_flush;
    logic        w_stall;
    ex_mem_t     w_ex_mem;

    int n_cmp = 0;
    int n_err = 0;

    // Reference view of the last instruction that reached EX/MEM.
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    rd_data_sel_e m_sel = RD_DATA_ALU;
    logic [31:0] m_res  = 32'd0;

    panda_ex_stage #(.MD_FAST_SPECIAL(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .id_ex_i      (r_id_ex),
        .wb_rd_data_i (r_wb_data),
        .wb_rd_addr_i (r_wb_addr),
        .wb_rd_we_i   (r_wb_we),
        .flush_i      (r_flush),
        .stall_o      (w_stall),
        .ex_mem_o     (w_ex_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] addr, input logic [31:0] d);
        if (addr != 0 && m_we && m_addr == addr && m_sel == RD_DATA_ALU) return m_res;
        if (addr != 0 && r_wb_we && r_wb_addr == addr) return r_wb_data;
        return d;
    endfunction

    function automatic logic [31:0] model_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            ALU_SUB:    return a - b;
            ALU_SLL:    return a << sh;
            ALU_SLT:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:    return a ^ b;
            ALU_SRL:    return a >> sh;
            ALU_SRA:    return 32'(int'(a) >>> sh);
            ALU_OR:     return a | b;
            ALU_AND:    return a & b;
            ALU_PASS_B: return b;
            default:    return a + b;
        endcase
    endfunction

    function automatic bit is_ovf(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        return (op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] model_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            MD_MUL:    begin p = ua * ub; return p[31:0];  end
            MD_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_MULHSU: begin p = sa * ub; return p[63:32]; end
            MD_MULHU:  begin p = ua * ub; return p[63:32]; end
            MD_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (is_ovf(op, a, b)) return a;
                p = sa / sb; return p[31:0];
            end
            MD_DIVU:   begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            MD_REM:    begin
                if (b == 0) return a;
                if (is_ovf(op, a, b)) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default:   begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic id_ex_t mk(input alu_op_e op, input logic [4:0] ra1, input logic [31:0] d1,
                                  input logic [4:0] ra2, input logic [31:0] d2,
                                  input logic [31:0] imm, input logic src_imm,
                                  input logic md, input md_op_e mop, input logic [4:0] rd);
        id_ex_t t;
        t = '0;
        t.valid = 1'b1;     t.pc_inc = $urandom;
        t.rs1_addr = ra1;   t.rs1_data = d1;
        t.rs2_addr = ra2;   t.rs2_data = d2;
        t.imm = imm;        t.alu_src_imm = src_imm;
        t.alu_op = op;      t.md_en = md;   t.md_op = mop;
        t.rd_addr = rd;     t.rd_we = 1'b1; t.rd_data_sel = RD_DATA_ALU;
        return t;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the result is visible.
    task automatic run_instr(input id_ex_t ins, input string tag);
        logic [31:0] a, b, exp;
        int exp_stall, cnt;
        r_id_ex = ins;
        a = model_fwd(ins.rs1_addr, ins.rs1_data);
        b = model_fwd(ins.rs2_addr, ins.rs2_data);
        if (ins.md_en) begin
            exp = model_md(ins.md_op, a, b);
            exp_stall = (ins.md_op[2] && (b == 0 || is_ovf(ins.md_op, a, b))) ? 1 : 33;
        end else begin
            exp = model_alu(ins.alu_op, a, ins.alu_src_imm ? ins.imm : b);
            exp_stall = 0;
        end
        #1;
        cnt = 0;
        while (w_stall && cnt < 40) begin
            cnt++;
            @(posedge clk); #1;
            r_wb_data = $urandom;
            r_wb_addr = 5'($urandom_range(0, 3));
            check({tag, " bubble"}, {63'd0, w_ex_mem.rd_we}, 64'd0);
        end
        check({tag, " stall_cycles"}, 64'(cnt), 64'(exp_stall));
        @(posedge clk); #1;
        check({tag, " result"}, {32'd0, w_ex_mem.alu_result}, {32'd0, exp});
        check({tag, " rd_we"}, {63'd0, w_ex_mem.rd_we}, {63'd0, ins.rd_we});
        check({tag, " rd_addr"}, {59'd0, w_ex_mem.rd_addr}, {59'd0, ins.rd_addr});
        if (!ins.md_en)
            check({tag, " rs2_data"}, {32'd0, w_ex_mem.rs2_data}, {32'd0, b});
        m_we = ins.rd_we; m_addr = ins.rd_addr; m_sel = ins.rd_data_sel; m_res = exp;
    endtask

    initial begin
        id_ex_t t;
        rst = 1'b1; r_flush = 1'b0; r_id_ex = '0;
        r_wb_we = 1'b0; r_wb_addr = 5'd0; r_wb_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ex_mem", {63'd0, |w_ex_mem}, 64'd0);
        check("reset stall", {63'd0, w_stall}, 64'd0);
        rst = 1'b0;

        run_instr(mk(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 1'b0, MD_MUL, 5'd3), "add5_7");
        run_instr(mk(ALU_ADD, 5'd4, 32'd1, 5'd5, 32'd2, 32'd0, 1'b0, 1'b0, MD_MUL, 5'd1), "add1_2");
        r_wb_we = 1'b1; r_wb_addr = 5'd1; r_wb_data = 32'd99;
        run_instr(mk(ALU_ADD, 5'd1, 32'd0, 5'd0, 32'd0, 32'd10, 1'b1, 1'b0, MD_MUL, 5'd2), "fwd_exmem");
        check("fwd_exmem const", {32'd0, w_ex_mem.alu_result}, 64'd13);
        r_wb_we = 1'b0;

        run_instr(mk(ALU_ADD, 5'd0, 32'h8000_0000, 5'd0, 32'h8000_0000, 32'd0, 1'b0, 1'b1, MD_MULH, 5'd5), "mulh");
        check("mulh const", {32'd0, w_ex_mem.alu_result}, 64'h4000_0000);
        run_instr(mk(ALU_ADD, 5'd0, -32'sd7, 5'd0, 32'd2, 32'd0, 1'b0, 1'b1, MD_DIV, 5'd6), "div_m7_2");
        check("div const", {32'd0, w_ex_mem.alu_result}, 64'hFFFF_FFFD);
        run_instr(mk(ALU_ADD, 5'd0, -32'sd7, 5'd0, 32'd2, 32'd0, 1'b0, 1'b1, MD_REM, 5'd6), "rem_m7_2");
        run_instr(mk(ALU_ADD, 5'd0, 32'd1234, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, MD_DIVU, 5'd7), "divu_by0");
        run_instr(mk(ALU_ADD, 5'd0, 32'h8000_0000, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, MD_DIV, 5'd7), "div_ovf");

        // Flush a DIV part-way through its iterations.
        r_id_ex = mk(ALU_ADD, 5'd0, 32'd100, 5'd0, 32'd7, 32'd0, 1'b0, 1'b1, MD_DIV, 5'd8);
        repeat (11) @(posedge clk);
        #1; r_flush = 1'b1;
        @(posedge clk); #1;
        r_flush = 1'b0;
        t = mk(ALU_SUB, 5'd0, 32'd50, 5'd0, 32'd8, 32'd0, 1'b0, 1'b0, MD_MUL, 5'd9);
        r_id_ex = t;
        #1;
        check("flush bubble", {63'd0, w_ex_mem.rd_we}, 64'd0);
        check("flush stall", {63'd0, w_stall}, 64'd0);
        m_we = 1'b0;
        run_instr(t, "after_flush");

        // Reset in the middle of a multiply.
        r_id_ex = mk(ALU_ADD, 5'd0, 32'd3, 5'd0, 32'd5, 32'd0, 1'b0, 1'b1, MD_MUL, 5'd10);
        repeat (5) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; r_id_ex.valid = 1'b0;
        #1;
        check("midreset stall", {63'd0, w_stall}, 64'd0);
        check("midreset ex_mem", {63'd0, |w_ex_mem}, 64'd0);
        m_we = 1'b0;
        @(posedge clk); #1;
        check("idle invalid stall", {63'd0, w_stall}, 64'd0);
        run_instr(mk(ALU_ADD, 5'd0, 32'd3, 5'd0, 32'd5, 32'd0, 1'b0, 1'b1, MD_MUL, 5'd10), "mul_after_rst");

        for (int i = 0; i < 60; i++) begin
            t = mk(alu_op_e'($urandom_range(0, 10)), 5'($urandom_range(0, 3)), pick_val(),
                   5'($urandom_range(0, 3)), pick_val(), $urandom, 1'($urandom),
                   ($urandom_range(0, 9) < 3), md_op_e'($urandom_range(0, 7)),
                   5'($urandom_range(0, 3)));
            t.rd_we = 1'($urandom);
            if (!t.md_en) t.rd_data_sel = rd_data_sel_e'($urandom_range(0, 2));
            r_wb_we   = 1'($urandom);
            r_wb_addr = 5'($urandom_range(0, 3));
            r_wb_data = $urandom;
            run_instr(t, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/panda_ex_stage.md
Name: panda_ex_stage

Overview:
- Execute stage of the Panda 5-stage pipeline. Sits between the ID/EX register (id_ex_t) and the MEM stage (ex_mem_t).
- Resolves operand forwarding and runs the single-cycle ALU.
- Adds an iterative RV32M multiply/divide unit that stalls the front end while it is busy.
- Registers all results into ex_mem_o.

Parameters:
- MD_FAST_SPECIAL, 1, when 1, divide-by-zero and signed-overflow divides skip the iterations and complete in one extra cycle.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- id_ex_i  in  id_ex_t  decoded instruction. Fields: valid, pc_inc, rs1/rs2 addr+data, imm, alu_op, alu_src_imm, md_en, md_op[2:0], lsu_*, rd_addr, rd_we, rd_data_sel.
- wb_rd_data_i  in  32  value being written back this cycle.
- wb_rd_addr_i  in  5  write-back destination.
- wb_rd_we_i  in  1  write-back enable.
- flush_i  in  1  kill the instruction currently in EX.
- stall_o  out  1  hold IF/ID/ID-EX registers.
- ex_mem_o  out  ex_mem_t  registered EX/MEM pipeline register.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - every ex_mem_o field = 0 (rd_data_sel = rd_data_sel_e'(0));
  - muldiv state = IDLE;
  - stall_o = 0.
- Forwarding, per source rs1/rs2, for addr != 0:
  - 1st priority: ex_mem_o.rd_we && ex_mem_o.rd_addr match && rd_data_sel == RD_DATA_ALU → use ex_mem_o.alu_result.
  - 2nd priority: wb_rd_we_i && wb_rd_addr_i match → use wb_rd_data_i.
  - Otherwise: id_ex_i data.
  - Load-use hazards are ID's job. A matching load in EX/MEM does not forward here.
- ALU:
  - operand B = imm if alu_src_imm, else forwarded rs2.
  - Combinational; result available in the same cycle.
- Non-muldiv instruction: the ex_mem_o fields below load at the next edge, with no stall.
  - alu_result;
  - forwarded rs2 → rs2_data;
  - rs2_addr, imm, pc_inc;
  - lsu_* fields;
  - rd_* fields.
- Muldiv FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL/DIV when id_ex_i.valid && md_en && !flush_i.
    - Operands are latched at this edge: forwarded values converted to magnitude; sign flags kept per md_op.
    - Iteration counter is set to 31.
  - MUL: shift-add, 1 bit per cycle, into a 64-bit accumulator. → DONE when counter = 0.
  - DIV: restoring divide, 1 bit per cycle. Produces 32-bit quotient and remainder. → DONE when counter = 0.
  - DONE: result is sign-corrected and selected per md_op:
    - MUL → low 32 bits.
    - MULH/MULHSU/MULHU → high 32 bits.
    - DIV/DIVU → quotient.
    - REM/REMU → remainder.
    - ex_mem_o loads the result as alu_result at this edge; the FSM returns to IDLE.
  - Special cases (MD_FAST_SPECIAL=1) go IDLE→DONE directly:
    - divisor 0 → quotient 0xFFFF_FFFF, remainder = dividend;
    - DIV/REM of 0x8000_0000 by −1 → quotient 0x8000_0000, remainder 0.
  - Sign rules:
    - quotient is negated if the operand signs differ;
    - remainder takes the dividend's sign;
    - product is negated if the signed operand signs differ.
- stall_o timing:
  - stall_o = (state==IDLE && muldiv start condition) || state==MUL || state==DIV. Combinational.
  - Instruction entering at cycle T (iterative): stall_o high T..T+32; DONE at T+33 with stall_o low; result is in ex_mem_o from T+34.
  - Fast-special path: stall_o high at T only; result is in ex_mem_o from T+2.
- Bubbles: while stall_o=1, ex_mem_o loads a bubble (rd_we=0, lsu_store=0, lsu width irrelevant). MEM never sees a duplicate.
- Operand stability: operands are latched at the start edge. Later changes to forwarding sources or id_ex_i do not affect the result.
- flush_i:
  - flush_i=1 → ex_mem_o loads a bubble, and the FSM goes to IDLE from any state.
  - flush_i has priority over DONE capture and over a new start.
- id_ex_i.valid=0 → bubble, no FSM start.

Decomposition:
- panda_pkg gains:
  - md_op_e (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU);
  - md_state_e;
  - id_ex_t fields md_en, md_op, valid.
- Sub-module panda_muldiv owns:
  - the FSM, counter, accumulator and sign correction;
  - interface: start, op, a, b, flush → busy, done, result.
- The existing ALU is reused unchanged.

Test Plan:
- ADD x3 (rs1 = 5, rs2 = 7) → ex_mem_o.alu_result = 12 one cycle later, stall_o never high.
- Back-to-back: ADD x1←1+2, then ADD x2←x1+10 with stale x1 = 0 → second result 13 via EX/MEM forward. With the same rd also in WB, the EX/MEM value wins.
- MULH with 0x8000_0000 × 0x8000_0000 → stall_o high 33 cycles, result 0x4000_0000. In that window, ex_mem_o.rd_we = 0.
- DIV −7/2 → result −3 (0xFFFF_FFFD); REM −7/2 → −1.
- DIVU x/0 → 0xFFFF_FFFF. DIV 0x8000_0000/−1 → 0x8000_0000, stall_o high exactly 1 cycle.
- flush_i at iteration 10 of a DIV → ex_mem_o bubble, stall_o low next cycle, a following ADD completes normally.
- rst_i asserted mid-MUL → next cycle: state IDLE, stall_o 0, ex_mem_o all zero.
